// File: rtl/minimax_pkg.sv
// ============================================================================
// minimax_pkg -- shared types for the minimax register-file dump block
// Rev 1.0
// ============================================================================
`default_nettype none

package minimax_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;
   localparam int BEAT_W    = DATA_W + REG_IDX_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [REG_IDX_W-1:0] idx;
      logic                 last;
   } beat_t;

endpackage

`default_nettype wire

// File: rtl/minimax_rf_dump_fifo.sv
// ============================================================================
// minimax_rf_dump_fifo -- synchronous output buffer with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module minimax_rf_dump_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 38
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/minimax_rf_dump.sv
// ============================================================================
// minimax_rf_dump -- halts the core and streams a register range out
// Rev 1.0
// ============================================================================
`default_nettype none

module minimax_rf_dump
   import minimax_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [REG_IDX_W-1:0] first_reg,
   input  logic [REG_IDX_W-1:0] last_reg,
   output logic                 halt_req,
   input  logic                 halted,
   output logic [REG_IDX_W-1:0] rf_addr,
   input  logic [DATA_W-1:0]    rf_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [REG_IDX_W-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   state_t               state_q, state_d;
   logic [REG_IDX_W-1:0] idx_q, idx_d;
   logic [REG_IDX_W-1:0] last_q, last_d;
   logic                 push;
   logic                 pop;
   logic                 fifo_full, fifo_empty;
   beat_t                push_beat, head_beat;
   logic [BEAT_W-1:0]    fifo_head;

   assign push_beat = '{data: rf_data, idx: idx_q, last: (idx_q == last_q)};
   assign head_beat = fifo_head;
   assign pop       = out_valid && out_ready;

   minimax_rf_dump_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (abort),
      .push      (push),
      .push_data (push_beat),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Storage is not reset, so the head fields are masked until a beat is valid.
   assign out_valid = !fifo_empty;
   assign out_data  = out_valid ? head_beat.data : '0;
   assign out_idx   = out_valid ? head_beat.idx  : '0;
   assign out_last  = out_valid && head_beat.last;

   assign busy     = (state_q != ST_IDLE);
   assign halt_req = busy;
   assign done     = (state_q == ST_DONE);
   assign rf_addr  = (state_q == ST_READ) ? idx_q : '0;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && (first_reg <= last_reg)) begin
               idx_d   = first_reg;
               last_d  = last_reg;
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (halted) state_d = ST_READ;
         end
         ST_READ: begin
            // A full buffer still accepts a beat when the head leaves this cycle.
            if (halted && (!fifo_full || pop)) begin
               push = 1'b1;
               if (idx_q == last_q) state_d = ST_DRAIN;
               else                 idx_d   = idx_q + 5'd1;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         push    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

endmodule

`default_nettype wire
